// File: rtl/pll_reset_seq_if.sv
// Handshake bundle for pll_reset_seq: lock/request inputs and
// the sequenced reset, ready and lock-loss outputs.
interface pll_reset_seq_if;
  logic       locked;
  logic       sw_reset_req;
  logic       rst_core_o;
  logic       rst_periph_o;
  logic       ready_o;
  logic [7:0] loss_count_o;

  modport master (
    output locked,
    output sw_reset_req,
    input  rst_core_o,
    input  rst_periph_o,
    input  ready_o,
    input  loss_count_o
  );

  modport slave (
    input  locked,
    input  sw_reset_req,
    output rst_core_o,
    output rst_periph_o,
    output ready_o,
    output loss_count_o
  );
endinterface

// File: rtl/pll_reset_seq.sv
// PLL-lock qualified core/peripheral reset sequencer.
// Define PLL_RESET_SEQ_LOSS_CNT_EN to build the lock-loss counter.
module pll_reset_seq #(
  parameter int LOCK_STABLE_CYCLES = 1024,
  parameter int STAGE_GAP_CYCLES   = 16
) (
  input logic            clk,
  input logic            reset,
  pll_reset_seq_if.slave bus
);

  localparam int CW = $clog2(LOCK_STABLE_CYCLES);
  localparam int GW = (STAGE_GAP_CYCLES > 1) ?
                      $clog2(STAGE_GAP_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST =
    CW'(LOCK_STABLE_CYCLES - 1);
  localparam logic [GW-1:0] GAP_LAST =
    GW'(STAGE_GAP_CYCLES - 1);

  typedef enum logic [1:0] {
    WAIT_LOCK,
    CORE_UP,
    RUN,
    DRAIN
  } state_e;

  state_e        state_q, state_d;
  logic [1:0]    sync_q, sync_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [GW-1:0] gcnt_q, gcnt_d;
  logic          rst_core_q, rst_core_d;
  logic          rst_periph_q, rst_periph_d;
  logic          ready_q, ready_d;
  logic          lock_s;
  logic          sw;
  logic          lost;

  assign lock_s = sync_q[1];
  assign sw     = bus.sw_reset_req;

  always_comb begin
    sync_d  = {sync_q[0], bus.locked};
    state_d = state_q;
    cnt_d   = cnt_q;
    gcnt_d  = gcnt_q;
    lost    = 1'b0;
    unique case (state_q)
      WAIT_LOCK: begin
        if (sw || !lock_s) begin
          cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = CORE_UP;
          cnt_d   = '0;
          gcnt_d  = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      CORE_UP, RUN: begin
        // lock loss outranks a simultaneous software request
        if (!lock_s) begin
          state_d = WAIT_LOCK;
          lost    = 1'b1;
          cnt_d   = '0;
          gcnt_d  = '0;
        end else if (sw) begin
          state_d = DRAIN;
          gcnt_d  = '0;
        end else if (state_q == CORE_UP) begin
          if (gcnt_q == GAP_LAST) begin
            state_d = RUN;
            gcnt_d  = '0;
          end else begin
            gcnt_d = gcnt_q + 1'b1;
          end
        end
      end
      DRAIN: begin
        if (!lock_s) begin
          state_d = WAIT_LOCK;
          lost    = 1'b1;
          cnt_d   = '0;
          gcnt_d  = '0;
        end else if (gcnt_q == GAP_LAST) begin
          state_d = WAIT_LOCK;
          cnt_d   = '0;
          gcnt_d  = '0;
        end else begin
          gcnt_d = gcnt_q + 1'b1;
        end
      end
      default: begin
        state_d = WAIT_LOCK;
        cnt_d   = '0;
        gcnt_d  = '0;
      end
    endcase
    rst_core_d   = (state_d == WAIT_LOCK) ||
                   (state_d == DRAIN);
    rst_periph_d = (state_d != RUN);
    ready_d      = (state_d == RUN);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= WAIT_LOCK;
      sync_q       <= '0;
      cnt_q        <= '0;
      gcnt_q       <= '0;
      rst_core_q   <= 1'b1;
      rst_periph_q <= 1'b1;
      ready_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      sync_q       <= sync_d;
      cnt_q        <= cnt_d;
      gcnt_q       <= gcnt_d;
      rst_core_q   <= rst_core_d;
      rst_periph_q <= rst_periph_d;
      ready_q      <= ready_d;
    end
  end

  assign bus.rst_core_o   = rst_core_q;
  assign bus.rst_periph_o = rst_periph_q;
  assign bus.ready_o      = ready_q;

`ifdef PLL_RESET_SEQ_LOSS_CNT_EN
  logic [7:0] loss_q, loss_d;

  always_comb begin
    loss_d = loss_q;
    if (lost && loss_q != 8'hFF) begin
      loss_d = loss_q + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      loss_q <= 8'h00;
    end else begin
      loss_q <= loss_d;
    end
  end

  assign bus.loss_count_o = loss_q;
`else
  logic unused_lost;
  assign unused_lost      = lost;
  assign bus.loss_count_o = 8'h00;
`endif

endmodule
